// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage and the pipeline registers.
//   XLEN          - datapath width
//   NOP_INSTR     - bubble instruction (addi x0,x0,0)
//   fetch_state_t - fetch FSM states
//   word_align    - clears the byte-offset bits of an address
package fetch_stage_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // dead cycle after reset release
        REQ  = 2'd1,   // correct-path request outstanding
        DROP = 2'd2,   // wrong-path request outstanding, response is discarded
        HOLD = 2'd3    // response captured while decode stalls
    } fetch_state_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register with flush > load > stall > bubble priority.
// Reusable for other stage boundaries carrying an instruction and its PC.
//   clk, rst       - clock, asynchronous active-low reset
//   flush          - replace instruction with BUBBLE, clear valid (PCs hold)
//   stall          - hold all contents
//   load           - capture instr_in/pc_in/pcplus4_in and set valid
//   instr/pc/pcplus4/valid - registered outputs
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] BUBBLE = NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            stall,
    input  logic            load,
    input  logic [XLEN-1:0] instr_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] pcplus4_in,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pcplus4,
    output logic            valid
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr   <= BUBBLE;
            pc      <= '0;
            pcplus4 <= '0;
            valid   <= 1'b0;
        end else if (flush) begin
            // A flushed load is lost on purpose; flush only comes with a redirect.
            instr <= BUBBLE;
            valid <= 1'b0;
        end else if (load) begin
            instr   <= instr_in;
            pc      <= pc_in;
            pcplus4 <= pcplus4_in;
            valid   <= 1'b1;
        end else if (!stall) begin
            // Nothing delivered and decode is draining: insert a bubble.
            instr <= BUBBLE;
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns PCF, drives the instruction-memory req/valid
// handshake (one request outstanding at most) and feeds the IF/ID register.
//   clk, rst            - clock, asynchronous active-low reset
//   StallD, FlushD      - decode hazard controls
//   PCSrcE, PCTargetE   - execute-stage redirect (target word-aligned here)
//   ImemReq, ImemAddr   - fetch request and address
//   ImemValid, ImemRData- fetch response
//   InstrD, PCD, PCPlus4D, ValidD - IF/ID outputs
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           StallD,
    input  logic                           FlushD,
    input  logic                           PCSrcE,
    input  logic [fetch_stage_pkg::XLEN-1:0] PCTargetE,
    output logic                           ImemReq,
    output logic [fetch_stage_pkg::XLEN-1:0] ImemAddr,
    input  logic                           ImemValid,
    input  logic [fetch_stage_pkg::XLEN-1:0] ImemRData,
    output logic [fetch_stage_pkg::XLEN-1:0] InstrD,
    output logic [fetch_stage_pkg::XLEN-1:0] PCD,
    output logic [fetch_stage_pkg::XLEN-1:0] PCPlus4D,
    output logic                           ValidD
);

    import fetch_stage_pkg::*;

    fetch_state_t    state;
    logic [XLEN-1:0] pcf;
    logic [XLEN-1:0] redir;
    logic [XLEN-1:0] hold_buf;

    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pcf_plus4;
    logic            deliver;
    logic [XLEN-1:0] deliver_instr;

    assign target    = word_align(PCTargetE);
    assign pcf_plus4 = pcf + 32'd4;   // modulo 2^32, wraps silently

    // In DROP PCF still names the wrong-path request, so the address stays put.
    assign ImemReq  = (state == REQ) || (state == DROP);
    assign ImemAddr = pcf;

    // A redirect always beats a response or a buffered word.
    always_comb begin
        deliver       = 1'b0;
        deliver_instr = hold_buf;
        case (state)
            REQ: begin
                deliver       = ImemValid && !PCSrcE && !StallD;
                deliver_instr = ImemRData;
            end
            HOLD:    deliver = !PCSrcE && !StallD;
            default: deliver = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            pcf      <= RESET_PC;
            redir    <= '0;
            hold_buf <= '0;
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (PCSrcE) begin
                        if (ImemValid) begin
                            pcf <= target;
                        end else begin
                            redir <= target;
                            state <= DROP;
                        end
                    end else if (ImemValid) begin
                        if (!StallD) begin
                            pcf <= pcf_plus4;
                        end else begin
                            hold_buf <= ImemRData;
                            state    <= HOLD;
                        end
                    end
                end
                DROP: begin
                    if (ImemValid) begin
                        pcf   <= PCSrcE ? target : redir;
                        state <= REQ;
                    end else if (PCSrcE) begin
                        redir <= target;
                    end
                end
                HOLD: begin
                    if (PCSrcE) begin
                        pcf   <= target;
                        state <= REQ;
                    end else if (!StallD) begin
                        pcf   <= pcf_plus4;
                        state <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    if_id_reg #(
        .BUBBLE (NOP_INSTR)
    ) u_if_id (
        .clk        (clk),
        .rst        (rst),
        .flush      (FlushD),
        .stall      (StallD),
        .load       (deliver),
        .instr_in   (deliver_instr),
        .pc_in      (pcf),
        .pcplus4_in (pcf_plus4),
        .instr      (InstrD),
        .pc         (PCD),
        .pcplus4    (PCPlus4D),
        .valid      (ValidD)
    );

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [31:0] KEY = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        StallD = 1'b0, FlushD = 1'b0, PCSrcE = 1'b0, ImemValid = 1'b0;
    logic [31:0] PCTargetE = '0, ImemRData = '0;
    logic        ImemReq, ValidD;
    logic [31:0] ImemAddr, InstrD, PCD, PCPlus4D;

    int checks = 0;
    int failures = 0;

    fetch_stage dut (
        .clk(clk), .rst(rst), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .ImemReq(ImemReq), .ImemAddr(ImemAddr),
        .ImemValid(ImemValid), .ImemRData(ImemRData),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
    );

    always #5 clk = ~clk;

    // Memory responder: latency per request (lat<0 -> random 0..3)
    int lat = 0;
    bit busy = 0;
    int wcnt = 0;

    // Reference model: what the fetcher is doing, in transaction terms
    bit          m_dead, m_discard, m_held;
    logic [31:0] m_pc, m_redir, m_word;
    logic [31:0] e_instr, e_pcd, e_pc4;
    bit          e_valid;

    function automatic logic [129:0] dut_vec();
        return {ImemReq, ImemAddr, InstrD, PCD, PCPlus4D, ValidD};
    endfunction

    function automatic logic [129:0] exp_vec();
        return {~m_dead & ~m_held, m_pc, e_instr, e_pcd, e_pc4, e_valid};
    endfunction

    task automatic model_reset();
        m_dead = 1; m_discard = 0; m_held = 0;
        m_pc = 32'h0; m_redir = 0; m_word = 0;
        e_instr = NOP; e_pcd = 0; e_pc4 = 0; e_valid = 0;
        busy = 0;
    endtask

    // Drive one cycle of inputs, advance the model, and stop 1 time unit past the edge.
    task automatic step(input bit s, input bit f, input bit b, input logic [31:0] t);
        bit v, dlv;
        logic [31:0] tw, dword, dpc;
        v = 0;
        if (ImemReq === 1'b1) begin
            if (!busy) begin
                busy = 1;
                wcnt = (lat < 0) ? int'($urandom_range(0, 3)) : lat;
            end
            if (wcnt == 0) begin v = 1; busy = 0; end
            else wcnt--;
        end
        StallD = s; FlushD = f; PCSrcE = b; PCTargetE = t; ImemValid = v;
        ImemRData = v ? (ImemAddr ^ KEY) : $urandom;

        tw = {t[31:2], 2'b00};
        dlv = 0; dword = 0; dpc = m_pc;
        if (m_dead) begin
            m_dead = 0;
        end else if (m_held) begin
            if (b) begin m_held = 0; m_pc = tw; end
            else if (!s) begin dlv = 1; dword = m_word; m_pc = m_pc + 4; m_held = 0; end
        end else if (m_discard) begin
            if (v) begin m_pc = b ? tw : m_redir; m_discard = 0; end
            else if (b) m_redir = tw;
        end else begin
            if (b) begin
                if (v) m_pc = tw;
                else begin m_redir = tw; m_discard = 1; end
            end else if (v) begin
                if (!s) begin dlv = 1; dword = m_pc ^ KEY; m_pc = m_pc + 4; end
                else begin m_held = 1; m_word = m_pc ^ KEY; end
            end
        end

        if (f) begin e_instr = NOP; e_valid = 0; end
        else if (dlv) begin e_instr = dword; e_pcd = dpc; e_pc4 = dpc + 4; e_valid = 1; end
        else if (!s) begin e_instr = NOP; e_valid = 0; end

        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 0;
        StallD = 0; FlushD = 0; PCSrcE = 0; ImemValid = 0;
        model_reset();
        @(posedge clk); #1;
        rst = 1;
    endtask

    task automatic test_reset();
        #2 rst = 0;
        model_reset();
        #1;
        checks++;
        if (dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL reset_state: dut=%h exp=%h", dut_vec(), exp_vec());
        end
        @(posedge clk); #1;
        rst = 1;
    endtask

    task automatic test_zero_wait();
        do_reset();
        lat = 0;
        step(0, 0, 0, 0);
        checks++;
        if (ImemReq !== 1'b1 || ValidD !== 1'b0 || ImemAddr !== 32'h0) begin
            failures++;
            $display("FAIL zero_wait_idle: req=%b valid=%b addr=%h want 1 0 0", ImemReq, ValidD, ImemAddr);
        end
        for (int i = 0; i < 3; i++) begin
            logic [31:0] pe;
            step(0, 0, 0, 0);
            pe = 32'(i * 4);
            checks++;
            if (PCD !== pe || PCPlus4D !== pe + 4 || InstrD !== (pe ^ KEY) || ValidD !== 1'b1) begin
                failures++;
                $display("FAIL zero_wait_pc%0d: pcd=%h pc4=%h instr=%h v=%b want pcd=%h", i, PCD, PCPlus4D, InstrD, ValidD, pe);
            end
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL zero_wait_model%0d: dut=%h exp=%h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_latency();
        logic [31:0] seq, prev_addr;
        bit prev_req;
        do_reset();
        lat = 2;
        seq = 0;
        for (int i = 0; i < 12; i++) begin
            prev_req = ImemReq;
            prev_addr = ImemAddr;
            step(0, 0, 0, 0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL latency_model%0d: dut=%h exp=%h", i, dut_vec(), exp_vec());
            end
            if (prev_req && !ImemValid) begin
                checks++;
                if (ImemAddr !== prev_addr) begin
                    failures++;
                    $display("FAIL latency_addr_stable%0d: addr=%h want %h", i, ImemAddr, prev_addr);
                end
            end
            if (ValidD === 1'b1) begin
                checks++;
                if (PCD !== seq) begin
                    failures++;
                    $display("FAIL latency_seq: pcd=%h want %h", PCD, seq);
                end
                seq = seq + 4;
            end
        end
        checks++;
        if (seq < 32'd8) begin
            failures++;
            $display("FAIL latency_progress: delivered up to %h want >= 8", seq);
        end
    endtask

    task automatic test_stall();
        do_reset();
        lat = 0;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);             // PCD=4, request for 8 pending
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0);
            checks++;
            if (ImemReq !== 1'b0 || PCD !== 32'h4 || ValidD !== 1'b1 || InstrD !== (32'h4 ^ KEY)) begin
                failures++;
                $display("FAIL stall_hold%0d: req=%b pcd=%h v=%b instr=%h want 0 4 1 %h", i, ImemReq, PCD, ValidD, InstrD, 32'h4 ^ KEY);
            end
        end
        step(0, 0, 0, 0);
        checks++;
        if (PCD !== 32'h8 || ValidD !== 1'b1 || InstrD !== (32'h8 ^ KEY) || ImemAddr !== 32'hC || ImemReq !== 1'b1) begin
            failures++;
            $display("FAIL stall_release: pcd=%h v=%b instr=%h addr=%h want 8 1 %h c", PCD, ValidD, InstrD, ImemAddr, 32'h8 ^ KEY);
        end
        checks++;
        if (dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL stall_model: dut=%h exp=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_redirect();
        int n;
        do_reset();
        lat = 0;
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);   // delivers 0..C, ImemAddr=0x10
        lat = 3;
        step(0, 0, 1, 32'h103);
        n = 0;
        while (m_discard && n < 10) begin
            checks++;
            if (ImemAddr !== 32'h10 || ImemReq !== 1'b1 || ValidD !== 1'b0) begin
                failures++;
                $display("FAIL redirect_drop%0d: addr=%h req=%b v=%b want 10 1 0", n, ImemAddr, ImemReq, ValidD);
            end
            lat = 0;
            step(0, 0, 0, 0);
            n++;
        end
        checks++;
        if (m_discard || ImemAddr !== 32'h100 || ValidD !== 1'b0) begin
            failures++;
            $display("FAIL redirect_target: addr=%h v=%b want 100 0", ImemAddr, ValidD);
        end
        step(0, 0, 0, 0);
        checks++;
        if (PCD !== 32'h100 || ValidD !== 1'b1 || InstrD !== (32'h100 ^ KEY)) begin
            failures++;
            $display("FAIL redirect_deliver: pcd=%h v=%b instr=%h want 100 1 %h", PCD, ValidD, InstrD, 32'h100 ^ KEY);
        end
    endtask

    task automatic test_flush_wrap();
        do_reset();
        lat = 0;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);                  // PCD=0 delivered
        step(1, 1, 0, 0);                  // flush+stall while the word for 4 arrives
        checks++;
        if (InstrD !== NOP || ValidD !== 1'b0 || PCD !== 32'h0) begin
            failures++;
            $display("FAIL flush_stall: instr=%h v=%b pcd=%h want 13 0 0", InstrD, ValidD, PCD);
        end
        step(0, 1, 1, 32'hFFFF_FFFE);      // redirect out of HOLD, target aligned to ...FC
        checks++;
        if (dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL flush_redirect: dut=%h exp=%h", dut_vec(), exp_vec());
        end
        step(0, 0, 0, 0);
        checks++;
        if (PCD !== 32'hFFFF_FFFC || PCPlus4D !== 32'h0 || ValidD !== 1'b1 || ImemAddr !== 32'h0) begin
            failures++;
            $display("FAIL wrap: pcd=%h pc4=%h v=%b addr=%h want fffffffc 0 1 0", PCD, PCPlus4D, ValidD, ImemAddr);
        end
        step(0, 1, 0, 0);                  // deliver of 0 is flushed
        checks++;
        if (InstrD !== NOP || ValidD !== 1'b0 || PCD !== 32'hFFFF_FFFC || ImemAddr !== 32'h4) begin
            failures++;
            $display("FAIL flush_deliver: instr=%h v=%b pcd=%h addr=%h want 13 0 fffffffc 4", InstrD, ValidD, PCD, ImemAddr);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        lat = 0;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        lat = 3;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);                  // mid-wait
        #2 rst = 0;
        #1;
        model_reset();
        checks++;
        if (dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL async_reset: dut=%h exp=%h", dut_vec(), exp_vec());
        end
        @(posedge clk); #1;
        rst = 1;
        lat = 0;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        checks++;
        if (PCD !== 32'h0 || ValidD !== 1'b1 || InstrD !== KEY) begin
            failures++;
            $display("FAIL async_restart: pcd=%h v=%b instr=%h want 0 1 %h", PCD, ValidD, InstrD, KEY);
        end
    endtask

    task automatic test_random();
        do_reset();
        lat = -1;
        for (int i = 0; i < 1500; i++) begin
            bit s, f, b;
            s = ($urandom_range(0, 99) < 30);
            b = ($urandom_range(0, 99) < 10);
            f = b ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 99) < 3);
            step(s, f, b, $urandom);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random%0d: dut=%h exp=%h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_latency();
        test_stall();
        test_redirect();
        test_flush_wrap();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
